tdm_nibble_rx: RTL and testbench
================================

// Module: tdm_nibble_rx
//
// PURPOSE
// Receive end of the nibble time-division link. The transmit side walks its
// NUM_CH switch nibbles onto a DATA_W-bit bus, one slot per beat; this block
// finds frame alignment from rx_sync, locks after LOCK_FRAMES clean frames and
// commits each complete frame atomically to led[]. It sits between the link pins
// and the LED drivers and replaces the combinational select-line demux.
//
// PARAMETERS
// NUM_CH      4   slots per frame; slot k drives led[DATA_W*k +: DATA_W]
// DATA_W      4   bits per slot
// LOCK_FRAMES 2   consecutive clean frames required before LOCKED (>=1)
// TIMEOUT     16  idle cycles (rx_valid low) tolerated mid-frame before re-hunt
//
// PORTS
// clk         in   1                system clock, rising edge
// reset       in   1                asynchronous, active-high
// rx_valid    in   1                beat strobe; rx_data/rx_sync are sampled only when high
// rx_data     in   DATA_W           slot payload
// rx_sync     in   1                high on slot 0 beat of every frame, low otherwise
// led         out  NUM_CH*DATA_W    committed frame, slot k at led[DATA_W*k +: DATA_W]
// locked      out  1                high while in LOCKED
// frame_done  out  1                1-cycle pulse on every commit to led
// sync_err    out  1                1-cycle pulse on any alignment violation or timeout
//
// BEHAVIOUR
// - Reset (async, any cycle): led=0, locked=0, frame_done=0, sync_err=0,
//   state=HUNT, slot_cnt=0, good_cnt=0, idle_cnt=0, shadow regs=0.
// - All outputs are registers. A beat accepted at edge N is reflected at edge N.
//   No output is combinational from an input.
// - States:
//   - HUNT: beats with rx_sync=0 are discarded with no sync_err. A beat with
//     rx_sync=1 stores shadow[0] and sets slot_cnt=1, good_cnt=0 -> CHECK.
//   - CHECK: each beat is checked. Expected rx_sync is (slot_cnt==0).
//     - Good beat: shadow[slot_cnt] <= rx_data. slot_cnt increments and wraps
//       from NUM_CH-1 to 0.
//     - Last slot: good_cnt++. When good_cnt reaches LOCK_FRAMES, go to LOCKED
//       and commit this frame.
//   - LOCKED: same checking. Each last-slot beat commits the frame.
// - Commit: at the edge accepting slot NUM_CH-1, led <= {rx_data, shadow[NUM_CH-2..0]}
//   and frame_done=1 for that cycle only. led never shows a partial frame.
// - Violations in CHECK or LOCKED. Each sets sync_err=1 for one cycle,
//   locked=0 and good_cnt=0. led holds its last committed value.
//   - rx_sync=1 at slot_cnt!=0 (early sync): the beat is taken as slot 0 of a
//     new frame. shadow[0] <= rx_data, slot_cnt=1 -> CHECK.
//   - rx_sync=0 at slot_cnt==0 (missing sync): the beat is discarded -> HUNT.
// - Timeout: idle_cnt counts cycles with rx_valid low while in CHECK or LOCKED,
//   and clears on any beat. When idle_cnt reaches TIMEOUT: sync_err pulse,
//   -> HUNT, locked=0. Idle cycles in HUNT are not counted.
// - slot_cnt width is clog2(NUM_CH). good_cnt saturates at LOCK_FRAMES.
// - With LOCK_FRAMES=1, the first clean frame both locks and commits.
//
// TESTING
// T1 Reset: assert reset mid-frame, between edges -> all outputs 0 immediately.
//    After release, beats with no sync are ignored, with no sync_err.
// T2 Lock: send 2 frames of slots 9,5,A,6, sync on slot 0.
//    -> frame 1: no commit, locked=0.
//    -> frame 2 last beat: led=16'h6A59, frame_done one pulse, locked=1.
// T3 Missing sync while locked: a slot-0 beat arrives with rx_sync=0.
//    -> sync_err one pulse, locked=0, led stays 16'h6A59.
//    -> Two more clean frames of 1,2,3,4 -> led=16'h4321.
// T4 Early sync at slot 2 while locked -> sync_err one pulse, locked=0.
//    -> The next 3 beats complete a frame that restarted at the sync beat.
//    -> led is not updated until LOCK_FRAMES clean frames have passed.
// T5 Gaps: rx_valid low for 15 cycles mid-frame -> frame commits correctly.
//    Low for 16 cycles -> sync_err, locked=0, state HUNT.
// T6 Back-to-back: rx_valid held high for 8 frames of random data while locked.
//    -> 8 frame_done pulses, each led value equal to the frame sent.
//    -> Scoreboard against the transmit model.

Source files
------------

// File: rtl/tdm_nibble_rx.sv
// tdm_nibble_rx: nibble TDM link receiver with sync hunt, frame lock and atomic commit to led (ports: clk, reset, rx_valid, rx_data, rx_sync -> led, locked, frame_done, sync_err)
module tdm_nibble_rx #(
  parameter int NUM_CH      = 4,
  parameter int DATA_W      = 4,
  parameter int LOCK_FRAMES = 2,
  parameter int TIMEOUT     = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     rx_valid,
  input  logic [DATA_W-1:0]        rx_data,
  input  logic                     rx_sync,
  output logic [NUM_CH*DATA_W-1:0] led,
  output logic                     locked,
  output logic                     frame_done,
  output logic                     sync_err
);
  localparam int SW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int GW = $clog2(LOCK_FRAMES + 1);
  localparam int IW = $clog2(TIMEOUT + 1);
  typedef enum logic [1:0] {HUNT, CHECK, LOCKED} state_t;
  state_t state, state_nx;
  logic [SW-1:0] slot_cnt;
  logic [GW-1:0] good_cnt;
  logic [IW-1:0] idle_cnt;
  logic [(NUM_CH-1)*DATA_W-1:0] shadow;
  logic hunting, start, early, missing, good, last, lock_now, timeout;
  always_comb begin
    hunting  = state == HUNT;
    early    = rx_valid && !hunting && rx_sync && slot_cnt != '0;
    start    = rx_valid && rx_sync && (hunting || slot_cnt != '0);
    missing  = rx_valid && !hunting && !rx_sync && slot_cnt == '0;
    good     = rx_valid && !hunting && (rx_sync == (slot_cnt == '0));
    last     = good && slot_cnt == SW'(NUM_CH - 1);
    lock_now = last && (state == LOCKED || good_cnt == GW'(LOCK_FRAMES - 1));
    timeout  = !rx_valid && !hunting && idle_cnt == IW'(TIMEOUT - 1);
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= HUNT;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    if (timeout || missing) state_nx = HUNT;
    else if (start) state_nx = CHECK;
    else if (lock_now) state_nx = LOCKED;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      led        <= '0;
      locked     <= 1'b0;
      frame_done <= 1'b0;
      sync_err   <= 1'b0;
      slot_cnt   <= '0;
      good_cnt   <= '0;
      idle_cnt   <= '0;
      shadow     <= '0;
    end else begin
      frame_done <= lock_now;
      sync_err   <= early || missing || timeout;
      locked     <= state_nx == LOCKED;
      idle_cnt   <= (rx_valid || hunting || timeout) ? '0 : idle_cnt + IW'(1);
      if (lock_now) led <= {rx_data, shadow};
      slot_cnt <= start ? SW'(1) : (timeout || missing) ? '0 : good ? (last ? '0 : slot_cnt + SW'(1)) : slot_cnt;
      good_cnt <= (start || missing || timeout) ? '0 : (last && good_cnt < GW'(LOCK_FRAMES)) ? good_cnt + GW'(1) : good_cnt;
      for (int k = 0; k < NUM_CH - 1; k++)
        if ((start && k == 0) || (good && !last && slot_cnt == SW'(k))) shadow[k*DATA_W +: DATA_W] <= rx_data;
    end
endmodule

// File: tb/tb_tdm_nibble_rx.sv
// tb_tdm_nibble_rx: directed vector table plus hand sequences for gaps, back-to-back frames and async reset
module tb_tdm_nibble_rx;
  logic clk = 0, reset = 1, rx_valid = 0, rx_sync = 0;
  logic [3:0] rx_data = 0;
  logic [15:0] led;
  logic locked, frame_done, sync_err;
  int checks = 0, failures = 0;
  typedef struct {logic v; logic [3:0] d; logic s; logic [15:0] led; logic lk, fd, se;} vec_t;
  vec_t vecs[$];
  tdm_nibble_rx dut (
    .clk(clk), .reset(reset), .rx_valid(rx_valid), .rx_data(rx_data), .rx_sync(rx_sync),
    .led(led), .locked(locked), .frame_done(frame_done), .sync_err(sync_err)
  );
  always #5 clk = ~clk;
  task automatic chk(input string n, input logic [15:0] a, input logic [15:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", n, a, e);
    end
  endtask
  task automatic chk_all(input string n, input logic [15:0] l, input logic lk, input logic fd, input logic se);
    chk({n, " led"}, led, l);
    chk({n, " locked"}, {15'b0, locked}, {15'b0, lk});
    chk({n, " frame_done"}, {15'b0, frame_done}, {15'b0, fd});
    chk({n, " sync_err"}, {15'b0, sync_err}, {15'b0, se});
  endtask
  function automatic void add(input logic v, input logic [3:0] d, input logic s, input logic [15:0] l,
                              input logic lk, input logic fd, input logic se);
    vecs.push_back('{v, d, s, l, lk, fd, se});
  endfunction
  task automatic beat(input logic v, input logic [3:0] d, input logic s);
    @(negedge clk);
    rx_valid = v;
    rx_data  = d;
    rx_sync  = s;
    @(posedge clk);
    #1;
  endtask
  initial begin
    logic [15:0] f;
    int pulses;
    // T1 prelude and T2 lock
    add(1, 4'h3, 0, 16'h0000, 0, 0, 0);
    add(1, 4'h7, 0, 16'h0000, 0, 0, 0);
    add(0, 4'h0, 0, 16'h0000, 0, 0, 0);
    add(1, 4'h9, 1, 16'h0000, 0, 0, 0);
    add(1, 4'h5, 0, 16'h0000, 0, 0, 0);
    add(1, 4'hA, 0, 16'h0000, 0, 0, 0);
    add(1, 4'h6, 0, 16'h0000, 0, 0, 0);
    add(1, 4'h9, 1, 16'h0000, 0, 0, 0);
    add(1, 4'h5, 0, 16'h0000, 0, 0, 0);
    add(1, 4'hA, 0, 16'h0000, 0, 0, 0);
    add(1, 4'h6, 0, 16'h6A59, 1, 1, 0);
    // T3 missing sync then relock
    add(1, 4'h1, 0, 16'h6A59, 0, 0, 1);
    add(1, 4'h1, 1, 16'h6A59, 0, 0, 0);
    add(1, 4'h2, 0, 16'h6A59, 0, 0, 0);
    add(1, 4'h3, 0, 16'h6A59, 0, 0, 0);
    add(1, 4'h4, 0, 16'h6A59, 0, 0, 0);
    add(1, 4'h1, 1, 16'h6A59, 0, 0, 0);
    add(1, 4'h2, 0, 16'h6A59, 0, 0, 0);
    add(1, 4'h3, 0, 16'h6A59, 0, 0, 0);
    add(1, 4'h4, 0, 16'h4321, 1, 1, 0);
    // T4 early sync at slot 2
    add(1, 4'h5, 1, 16'h4321, 1, 0, 0);
    add(1, 4'h6, 0, 16'h4321, 1, 0, 0);
    add(1, 4'h7, 1, 16'h4321, 0, 0, 1);
    add(1, 4'h8, 0, 16'h4321, 0, 0, 0);
    add(1, 4'h9, 0, 16'h4321, 0, 0, 0);
    add(1, 4'hA, 0, 16'h4321, 0, 0, 0);
    add(1, 4'hB, 1, 16'h4321, 0, 0, 0);
    add(1, 4'hC, 0, 16'h4321, 0, 0, 0);
    add(1, 4'hD, 0, 16'h4321, 0, 0, 0);
    add(1, 4'hE, 0, 16'hEDCB, 1, 1, 0);
    repeat (2) @(posedge clk);
    #1;
    chk_all("reset", 16'h0000, 0, 0, 0);
    @(negedge clk);
    reset = 0;
    foreach (vecs[i]) begin
      beat(vecs[i].v, vecs[i].d, vecs[i].s);
      chk_all($sformatf("vec%0d", i), vecs[i].led, vecs[i].lk, vecs[i].fd, vecs[i].se);
    end
    // T5 15-cycle gap survives
    beat(1, 4'h1, 1);
    beat(1, 4'h2, 0);
    for (int i = 0; i < 15; i++) begin
      beat(0, 4'h0, 0);
      chk($sformatf("t5 gap15 err%0d", i), {15'b0, sync_err}, 16'h0);
    end
    beat(1, 4'h3, 0);
    beat(1, 4'h4, 0);
    chk_all("t5 gap15 commit", 16'h4321, 1, 1, 0);
    // T5 16-cycle gap times out
    beat(1, 4'h5, 1);
    for (int i = 0; i < 15; i++) begin
      beat(0, 4'h0, 0);
      chk($sformatf("t5 gap16 err%0d", i), {15'b0, sync_err}, 16'h0);
    end
    beat(0, 4'h0, 0);
    chk_all("t5 timeout", 16'h4321, 0, 0, 1);
    for (int i = 0; i < 20; i++) begin
      beat(0, 4'h0, 0);
      chk($sformatf("t5 hunt idle%0d", i), {15'b0, sync_err}, 16'h0);
    end
    beat(1, 4'h6, 0);
    chk_all("t5 hunt discard", 16'h4321, 0, 0, 0);
    for (int r = 0; r < 2; r++) begin
      beat(1, 4'h7, 1);
      beat(1, 4'h8, 0);
      beat(1, 4'h9, 0);
      beat(1, 4'hA, 0);
      chk_all($sformatf("t5 relock%0d", r), r ? 16'hA987 : 16'h4321, r == 1, r == 1, 0);
    end
    // T6 back-to-back random frames
    pulses = 0;
    repeat (8) begin
      f = 16'($urandom);
      for (int k = 0; k < 4; k++) begin
        beat(1, f[4*k +: 4], k == 0);
        if (frame_done) pulses++;
        if (k == 3) chk("t6 led", led, f);
      end
    end
    chk("t6 pulses", 16'(pulses), 16'd8);
    chk("t6 locked", {15'b0, locked}, 16'h1);
    // T1 async reset mid-frame
    beat(1, 4'h1, 1);
    beat(1, 4'h2, 0);
    #2 reset = 1;
    #1;
    chk_all("t1 async reset", 16'h0000, 0, 0, 0);
    @(negedge clk);
    reset = 0;
    beat(1, 4'h5, 0);
    chk_all("t1 post nosync a", 16'h0000, 0, 0, 0);
    beat(1, 4'h6, 0);
    chk_all("t1 post nosync b", 16'h0000, 0, 0, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
